// File: rtl/fixed_point_multiplier.sv
// fixed_point_multiplier
//   Sequential unsigned fixed-point multiplier, Q(W-F).F x Q(W-F).F -> Q(W-F).F.
//   Shift-add datapath, one partial product per clock (W iterations), with
//   saturation on integer overflow and truncation of the dropped fraction.
//   Shares the start/sclr/busy/valid handshake of the restoring divider.
//
// Ports
//   clk    in  1  clock, rising edge
//   rst    in  1  synchronous reset, active-low
//   sclr   in  1  synchronous clear, active-high (same effect as rst)
//   start  in  1  request a multiply (sampled in IDLE or DONE only)
//   a_in   in  W  multiplicand, unsigned Q(W-F).F
//   b_in   in  W  multiplier, unsigned Q(W-F).F
//   p_out  out W  product, held until the next result
//   ovf    out 1  product saturated (integer part did not fit)
//   busy   out 1  high while iterating
//   valid  out 1  one-cycle pulse when p_out/ovf are updated
module fixed_point_multiplier #(
   parameter int unsigned W = 10,
   parameter int unsigned F = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sclr,
   input  logic         start,
   input  logic [W-1:0] a_in,
   input  logic [W-1:0] b_in,
   output logic [W-1:0] p_out,
   output logic         ovf,
   output logic         busy,
   output logic         valid
);

   localparam int unsigned CW = $clog2(W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [2*W-1:0]  r_p;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_p_out;
   logic            r_ovf;

   logic [W:0]      w_sum;
   logic [2*W-1:0]  w_p_next;
   logic            w_last;
   logic            w_res_ovf;
   logic [W-1:0]    w_res_p;
   logic            w_unused;

   // One shift-add step: conditionally add A into the upper half, then
   // shift {carry, P} right so the carry lands in the top bit.
   always_comb begin
      w_sum    = {1'b0, r_p[2*W-1:W]};
      if (r_b[0]) begin
         w_sum = {1'b0, r_p[2*W-1:W]} + {1'b0, r_a};
      end
      w_p_next = {w_sum, r_p[W-1:1]};
   end

   assign w_last = (r_cnt == CW'(W - 1));

   // Result is formed from the product as it stands after the final step.
   always_comb begin
      w_res_ovf = |w_p_next[2*W-1:W+F];
      w_res_p   = w_p_next[W+F-1:F];
      if (w_res_ovf) begin
         w_res_p = '1;
      end
   end

   // Low fraction bits of the product are discarded by truncation.
   assign w_unused = ^w_p_next;

   // State register
   always_ff @(posedge clk) begin
      if (!rst || sclr) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_next = CALC;
         CALC:    if (w_last) w_state_next = DONE;
         DONE:    w_state_next = start ? CALC : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Outputs decoded from the registered state
   always_comb begin
      busy  = 1'b0;
      valid = 1'b0;
      unique case (r_state)
         CALC:    busy  = 1'b1;
         DONE:    valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (!rst || sclr) begin
         r_a     <= '0;
         r_b     <= '0;
         r_p     <= '0;
         r_cnt   <= '0;
         r_p_out <= '0;
         r_ovf   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_a   <= a_in;
                  r_b   <= b_in;
                  r_p   <= '0;
                  r_cnt <= '0;
               end
            end
            CALC: begin
               r_p   <= w_p_next;
               r_b   <= {1'b0, r_b[W-1:1]};
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_p_out <= w_res_p;
                  r_ovf   <= w_res_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   assign p_out = r_p_out;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
module tb_fixed_point_multiplier;

   localparam int W = 10;
   localparam int F = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         sclr;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic [W-1:0] p_out;
   logic         ovf;
   logic         busy;
   logic         valid;

   always #5 clk = ~clk;

   fixed_point_multiplier #(.W(W), .F(F)) dut (
      .clk   (clk),
      .rst   (rst),
      .sclr  (sclr),
      .start (start),
      .a_in  (a_in),
      .b_in  (b_in),
      .p_out (p_out),
      .ovf   (ovf),
      .busy  (busy),
      .valid (valid)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [W-1:0] p;
      logic         o;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] p;
      logic         o;
   } vec_t;

   exp_t sb[$];

   function automatic void check(string name, longint act, longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endfunction

   // Reference: exact product, saturate if integer part overflows, else truncate.
   function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b);
      exp_t   e;
      longint full;
      full = longint'(a) * longint'(b);
      if ((full >> (W + F)) != 0) begin
         e.p = '1;
         e.o = 1'b1;
      end else begin
         e.p = W'(full >> F);
         e.o = 1'b0;
      end
      return e;
   endfunction

   // Scoreboard: every valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst && valid) begin
         exp_t e;
         if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            check("p_out", p_out, e.p);
            check("ovf", ovf, e.o);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Single operation; optionally pulses start mid-CALC with other operands.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ep, input logic eo, input int mid);
      exp_t e;
      e.p = ep;
      e.o = eo;
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      a_in  = ~a;
      b_in  = ~b;
      check("busy_edge0", busy, 1);
      check("valid_edge0", valid, 0);
      for (int k = 1; k <= W; k++) begin
         @(posedge clk);
         #1;
         if (k < W) begin
            if (busy !== 1'b1 || valid !== 1'b0) check("calc_flags", {busy, valid}, 2'b10);
         end else begin
            check("done_busy", busy, 0);
            check("done_valid", valid, 1);
         end
         start = (k == mid);
         if (k == mid) begin
            a_in = 10'd1023;
            b_in = 10'd1023;
         end
      end
      @(posedge clk);
      #1;
      check("valid_drop", valid, 0);
      check("p_hold", p_out, ep);
   endtask

   vec_t tbl[6];

   initial begin
      tbl[0] = '{a: 10'd80,   b: 10'd64,   p: 10'd160,  o: 1'b0};
      tbl[1] = '{a: 10'd1023, b: 10'd32,   p: 10'd1023, o: 1'b0};
      tbl[2] = '{a: 10'd1,    b: 10'd1,    p: 10'd0,    o: 1'b0};
      tbl[3] = '{a: 10'd0,    b: 10'd1023, p: 10'd0,    o: 1'b0};
      tbl[4] = '{a: 10'd1023, b: 10'd64,   p: 10'd1023, o: 1'b1};
      tbl[5] = '{a: 10'd96,   b: 10'd48,   p: 10'd144,  o: 1'b0};

      rst   = 1'b0;
      sclr  = 1'b0;
      start = 1'b1;
      a_in  = 10'd80;
      b_in  = 10'd64;
      repeat (2) @(posedge clk);
      #1;
      check("rst_p_out", p_out, 0);
      check("rst_ovf", ovf, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("idle_busy", busy, 0);
      end

      foreach (tbl[i]) run_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].o, -1);

      // Start pulse during CALC must not disturb the running operation.
      run_op(10'd80, 10'd64, 10'd160, 1'b0, 4);

      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         exp_t         m;
         ra = W'($urandom_range(0, 1023));
         rb = W'($urandom_range(0, 1023));
         m  = model(ra, rb);
         run_op(ra, rb, m.p, m.o, -1);
      end

      // Back-to-back: start held through DONE.
      begin
         exp_t e1;
         exp_t e2;
         e1.p = 10'd160;  e1.o = 1'b0;
         e2.p = 10'd1023; e2.o = 1'b1;
         @(negedge clk);
         a_in  = 10'd80;
         b_in  = 10'd64;
         start = 1'b1;
         sb.push_back(e1);
         @(posedge clk);
         #1;
         for (int k = 1; k <= 2 * W + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == W || k == 2 * W + 1) check("b2b_valid", valid, 1);
            else if (valid !== 1'b0) check("b2b_no_valid", valid, 0);
            if (k == W) begin
               a_in = 10'd1023;
               b_in = 10'd64;
               sb.push_back(e2);
            end
            if (k == W + 1) begin
               check("b2b_busy_restart", busy, 1);
               start = 1'b0;
            end
         end
         @(posedge clk);
         #1;
         check("b2b_valid_drop", valid, 0);
      end

      // Abort with sclr at the fifth CALC cycle.
      @(negedge clk);
      a_in  = 10'd80;
      b_in  = 10'd64;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("abort_pre_busy", busy, 1);
      @(negedge clk);
      sclr = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", busy, 0);
      check("abort_valid", valid, 0);
      check("abort_p_out", p_out, 0);
      check("abort_ovf", ovf, 0);
      sclr = 1'b0;
      for (int k = 0; k < W + 3; k++) begin
         @(posedge clk);
         #1;
         if (valid !== 1'b0 || busy !== 1'b0) check("abort_quiet", {busy, valid}, 0);
      end
      run_op(10'd96, 10'd48, 10'd144, 1'b0, -1);

      repeat (2) @(posedge clk);
      check("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fixed_point_multiplier.md
# fixed_point_multiplier

Sequential unsigned fixed-point multiplier, the companion to the team's restoring divider. It multiplies two unsigned Q(W−F).F operands and returns a W-bit product in the same format. It uses a shift-add datapath, one partial product per clock. It uses the same start/sclr/busy/valid handshake as the divider, so both can share the arithmetic unit's controller interface.

## Interface
- W, 10: operand and result width in bits.
- F, 5: number of fractional bits in operands and result (0 ≤ F < W).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- sclr  in  1  synchronous clear, active-high; same effect as reset.
- start  in  1  request a multiply; sampled only in IDLE or DONE.
- a_in  in  W  multiplicand, unsigned Q(W−F).F.
- b_in  in  W  multiplier, unsigned Q(W−F).F.
- p_out  out  W  product, unsigned Q(W−F).F; held until the next result.
- ovf  out  1  product integer part exceeds W−F bits; held with p_out.
- busy  out  1  high while computing.
- valid  out  1  one-cycle pulse when p_out/ovf are updated.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: busy=0, valid=0. If start=1:
  - latch a_in into A and b_in into B;
  - clear the 2W-bit accumulator P and the iteration counter;
  - go to CALC.
- CALC: busy=1. Each cycle:
  - if B[0]=1, add A to the upper W bits of P (W+1-bit sum);
  - shift {carry, P} right by 1;
  - shift B right by 1;
  - counter+1.
  - After exactly W iterations, go to DONE.
- Result formation on entry to DONE, from the full 2W-bit product P:
  - overflow = |P[2W−1 : W+F];
  - if overflow: p_out = all ones (saturate), ovf = 1;
  - else: p_out = P[W+F−1 : F] (truncation toward zero), ovf = 0.
- DONE: valid=1, busy=0, for one cycle. If start=1, load new operands and go to CALC (back-to-back). Otherwise go to IDLE.
- start in CALC is ignored; operands are not re-sampled.
- a_in/b_in changes after the start cycle have no effect.
- A zero operand is not an error: p_out=0, ovf=0.
- Reset (rst=0) or sclr=1, in any state:
  - next state IDLE;
  - A, B, P and counter cleared;
  - p_out=0, ovf=0, busy=0, valid=0.
  - If both are asserted, the effect is identical. They override start in the same cycle.

## Timing
- Reset values: p_out=0, ovf=0, busy=0, valid=0, state IDLE.
- Call the edge that samples start edge 0.
- busy is high after edges 0 through W−1. It is registered from the state, so it is high the cycle after start.
- After edge W:
  - state DONE;
  - p_out/ovf updated;
  - valid=1, busy=0.
- After edge W+1: valid=0.
- Latency: W+1 cycles from the start cycle to the valid cycle (11 for W=10).
- Throughput with start held high in DONE: one result per W+1 cycles.
- sclr/rst during CALC aborts the operation. No valid pulse is produced, and the old p_out is cleared to 0.
- The counter must terminate at W iterations without wrap for any W ≥ 2. Counter width is ceil(log2(W+1)).

## Test plan
- Reset: hold rst=0 for 2 cycles with start=1. Require p_out=0, ovf=0, busy=0, valid=0. Release rst; no activity without start.
- Basic, W=10, F=5: a_in=80 (2.5), b_in=64 (2.0), pulse start.
  - busy is high for 10 cycles.
  - valid pulses at cycle 11 with p_out=160 (5.0), ovf=0.
  - p_out holds 160 afterwards.
- Boundaries:
  - a_in=1023, b_in=32 (1.0): p_out=1023, ovf=0.
  - a_in=1, b_in=1: p_out=0 (truncation), ovf=0.
  - a_in=0, b_in=1023: p_out=0, ovf=0.
- Overflow: a_in=1023, b_in=64. The raw result is 2046, so require p_out=1023 (saturated), ovf=1.
- Handshake:
  - Pulse start mid-CALC with different operands; require the first result to be unaffected.
  - Hold start high through DONE; require the second operation to begin immediately, with two valid pulses 11 cycles apart.
- Abort: assert sclr at cycle 5 of CALC. Require IDLE next cycle, busy=0, no valid pulse, p_out=0. A fresh start then produces a correct result.
